bcd_counter: RTL and testbench

//   Registered N-digit packed-BCD up/down counter with synchronous clear, parallel load,

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit.sv | 40 ++++
 rtl/bcd_counter.sv | 90 +++++++++
 tb/tb_bcd_counter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the packed-BCD counter: digit type, digit limits
// and the nibble validity check.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit stepped up or down by one when step is high. ripple reports
// a carry (up) or borrow (down) into the next digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       down,
  input  logic       step,
  output bcd_digit_t next_digit,
  output logic       ripple
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_digit = digit;
    ripple     = 1'b0;
    if (step) begin
      if (!down) begin
        // Values above 9 are treated like 9: they roll to 0 and carry out.
        if (digit >= BCD_MAX) begin
          next_digit = BCD_MIN;
          ripple     = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (!is_bcd(digit)) begin
          next_digit = BCD_MAX - 4'd1;
        end else if (digit == BCD_MIN) begin
          next_digit = BCD_MAX;
          ripple     = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Registered N-digit packed-BCD up/down counter with clear, load, terminal
// count, carry pulse and sticky overflow. Define BCD_LOAD_CHECK_EN to reject
// loads containing non-BCD nibbles and pulse Invalid.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int SATURATE = 0
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Clear,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  input  logic                  Enable,
  input  logic                  Down,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  Terminal,
  output logic                  Carry,
  output logic                  Overflow,
  output logic                  Invalid
);

  localparam int W   = BCD_W * DIGITS;
  localparam bit SAT = (SATURATE != 0);

  logic [W-1:0]    stepped;
  logic [DIGITS:0] ripple;
  logic            limit;
  logic            load_ok;

  assign ripple[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .digit      (Count[i*BCD_W +: BCD_W]),
      .down       (Down),
      .step       (ripple[i]),
      .next_digit (stepped[i*BCD_W +: BCD_W]),
      .ripple     (ripple[i+1])
    );
  end

  // A ripple escaping the top digit is a wrap (or a blocked step when saturating).
  assign limit = ripple[DIGITS];

  assign Terminal = Down ? (Count == '0) : (Count == {DIGITS{BCD_MAX}});

`ifdef BCD_LOAD_CHECK_EN
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(LoadValue[i*BCD_W +: BCD_W])) load_ok = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) Invalid <= 1'b0;
    else          Invalid <= !Clear && Load && !load_ok;
  end
`else
  assign load_ok = 1'b1;
  assign Invalid = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values regardless of statement order.
    if (!Reset_n) begin
      Count    <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Carry <= 1'b0;
      if (Clear) begin
        Count    <= '0;
        Overflow <= 1'b0;
      end else if (Load) begin
        if (load_ok) Count <= LoadValue;
      end else if (Enable) begin
        if (!(limit && SAT)) Count <= stepped;
        if (limit) begin
          Carry    <= 1'b1;
          Overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter (DIGITS=3): directed vector table,
// hand-written corner sequences and a randomized run against a decimal model.
module tb_bcd_counter;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Clear, Load, Enable, Down;
  logic [11:0] LoadValue;

  logic [11:0] Count, s_count;
  logic        Terminal, Carry, Overflow, Invalid;
  logic        s_terminal, s_carry, s_overflow, s_invalid;

  int checks   = 0;
  int failures = 0;

`ifdef BCD_LOAD_CHECK_EN
  localparam bit CHECKED = 1'b1;
`else
  localparam bit CHECKED = 1'b0;
`endif

  always #5 Clock = ~Clock;

  bcd_counter #(.DIGITS(3), .SATURATE(0)) u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .Clear(Clear), .Load(Load),
    .LoadValue(LoadValue), .Enable(Enable), .Down(Down),
    .Count(Count), .Terminal(Terminal), .Carry(Carry),
    .Overflow(Overflow), .Invalid(Invalid)
  );

  bcd_counter #(.DIGITS(3), .SATURATE(1)) u_sat (
    .Clock(Clock), .Reset_n(Reset_n), .Clear(Clear), .Load(Load),
    .LoadValue(LoadValue), .Enable(Enable), .Down(Down),
    .Count(s_count), .Terminal(s_terminal), .Carry(s_carry),
    .Overflow(s_overflow), .Invalid(s_invalid)
  );

  typedef struct {
    logic        clear;
    logic        load;
    logic [11:0] lv;
    logic        en;
    logic        down;
    logic [11:0] exp_count;
    logic        exp_carry;
    logic        exp_ovf;
    logic        exp_term;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic clr, input logic ld, input logic [11:0] lv,
                     input logic en, input logic dn);
    Clear = clr; Load = ld; LoadValue = lv; Enable = en; Down = dn;
    @(posedge Clock);
    #1;
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic bit all_bcd(input logic [11:0] c);
    for (int i = 0; i < 3; i++) if (c[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int to_int(input logic [11:0] c);
    return int'(c[3:0]) + 10 * int'(c[7:4]) + 100 * int'(c[11:8]);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  function automatic void model_step(input logic [11:0] c, input logic dn,
                                     output logic [11:0] n, output logic wrapped);
    int v;
    bit go;
    logic [3:0] d;
    if (all_bcd(c)) begin
      v = to_int(c);
      if (!dn) begin wrapped = (v == 999); v = (v + 1) % 1000; end
      else     begin wrapped = (v == 0);   v = (v + 999) % 1000; end
      n = to_bcd(v);
    end else begin
      n  = c;
      go = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (go) begin
          d = c[i*4 +: 4];
          if (!dn) begin
            if (d >= 4'd9) d = 4'd0;
            else begin d = d + 4'd1; go = 1'b0; end
          end else begin
            if (d > 4'd9)       begin d = 4'd8; go = 1'b0; end
            else if (d == 4'd0) d = 4'd9;
            else                begin d = d - 4'd1; go = 1'b0; end
          end
          n[i*4 +: 4] = d;
        end
      end
      wrapped = go;
    end
  endfunction

  function automatic logic term_of(input logic [11:0] c, input logic dn);
    return dn ? (to_int(c) == 0 && all_bcd(c)) : (c == 12'h999);
  endfunction

  vec_t vecs[14];

  initial begin
    logic [11:0] m_cnt, s_cnt, nxt, rv;
    logic m_car, m_ovf, m_inv, s_car, s_ovf, wr;
    logic r_clr, r_ld, r_en, r_dn;

    Reset_n = 1'b0;
    Clear = 0; Load = 0; LoadValue = '0; Enable = 0; Down = 0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_count", 32'(Count), 32'h000);
    check("reset_carry", 32'(Carry), 32'h0);
    check("reset_ovf",   32'(Overflow), 32'h0);
    check("reset_inv",   32'(Invalid), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // clear, load, lv, en, down, count, carry, ovf, term
    vecs[0]  = '{0, 1, 12'h098, 0, 0, 12'h098, 0, 0, 0};
    vecs[1]  = '{0, 0, 12'h000, 1, 0, 12'h099, 0, 0, 0};
    vecs[2]  = '{0, 0, 12'h000, 1, 0, 12'h100, 0, 0, 0};
    vecs[3]  = '{0, 1, 12'h999, 0, 0, 12'h999, 0, 0, 1};
    vecs[4]  = '{0, 0, 12'h000, 1, 0, 12'h000, 1, 1, 0};
    vecs[5]  = '{0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0};
    vecs[6]  = '{0, 1, 12'h000, 0, 1, 12'h000, 0, 1, 1};
    vecs[7]  = '{0, 0, 12'h000, 1, 1, 12'h999, 1, 1, 0};
    vecs[8]  = '{0, 0, 12'h000, 1, 1, 12'h998, 0, 1, 0};
    vecs[9]  = '{1, 1, 12'h555, 1, 0, 12'h000, 0, 0, 0};
    vecs[10] = '{0, 1, 12'h509, 1, 1, 12'h509, 0, 0, 0};
    vecs[11] = '{0, 0, 12'h000, 1, 1, 12'h508, 0, 0, 0};
    vecs[12] = '{0, 1, 12'h500, 0, 1, 12'h500, 0, 0, 0};
    vecs[13] = '{0, 0, 12'h000, 1, 1, 12'h499, 0, 0, 0};

    foreach (vecs[i]) begin
      cyc(vecs[i].clear, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].down);
      check($sformatf("vec%0d_count", i), 32'(Count),    32'(vecs[i].exp_count));
      check($sformatf("vec%0d_carry", i), 32'(Carry),    32'(vecs[i].exp_carry));
      check($sformatf("vec%0d_ovf", i),   32'(Overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_term", i),  32'(Terminal), 32'(vecs[i].exp_term));
    end

    // Asynchronous reset mid-count with Overflow set.
    cyc(0, 1, 12'h999, 0, 0);
    cyc(0, 0, 12'h000, 1, 0);
    cyc(0, 1, 12'h457, 0, 0);
    check("pre_reset_count", 32'(Count), 32'h457);
    Enable = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    check("async_reset_count", 32'(Count), 32'h000);
    check("async_reset_carry", 32'(Carry), 32'h0);
    check("async_reset_ovf",   32'(Overflow), 32'h0);
    @(negedge Clock);
    Enable = 1'b0;
    Reset_n = 1'b1;

    // Saturating instance at both limits.
    cyc(1, 0, 12'h000, 0, 0);
    cyc(0, 1, 12'h000, 0, 1);
    cyc(0, 0, 12'h000, 1, 1);
    check("sat_down_count", 32'(s_count), 32'h000);
    check("sat_down_carry", 32'(s_carry), 32'h1);
    check("sat_down_ovf",   32'(s_overflow), 32'h1);
    check("wrap_down_count", 32'(Count), 32'h999);
    cyc(0, 1, 12'h999, 0, 0);
    cyc(0, 0, 12'h000, 1, 0);
    check("sat_up_count", 32'(s_count), 32'h999);
    check("sat_up_carry", 32'(s_carry), 32'h1);
    cyc(0, 0, 12'h000, 0, 0);
    check("sat_idle_carry", 32'(s_carry), 32'h0);
    check("sat_idle_count", 32'(s_count), 32'h999);

    // Load of a non-BCD value.
    cyc(0, 1, 12'h123, 0, 0);
    cyc(0, 1, 12'h1A3, 0, 0);
    if (CHECKED) begin
      check("bad_load_count", 32'(Count), 32'h123);
      check("bad_load_inv",   32'(Invalid), 32'h1);
      cyc(0, 0, 12'h000, 0, 0);
      check("bad_load_inv_end", 32'(Invalid), 32'h0);
      cyc(1, 1, 12'h1A3, 0, 0);
      check("clear_beats_bad_load", 32'(Count), 32'h000);
      check("clear_bad_load_inv",   32'(Invalid), 32'h0);
    end else begin
      check("raw_load_count", 32'(Count), 32'h1A3);
      check("raw_load_inv",   32'(Invalid), 32'h0);
      cyc(0, 0, 12'h000, 1, 0);
      check("raw_inc_count", 32'(Count), 32'h1A4);
    end

    // Randomized run against the decimal model, both instances.
    m_cnt = '0; s_cnt = '0; m_car = 0; m_ovf = 0; m_inv = 0; s_car = 0; s_ovf = 0;
    for (int n = 0; n < 600; n++) begin
      r_clr = (n == 0) || ($urandom_range(0, 15) == 0);
      r_ld  = ($urandom_range(0, 5) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_dn  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) rv = 12'($urandom);
      else rv = to_bcd(($urandom_range(0, 9) < 3) ? ($urandom_range(0, 1) ? 999 : 0)
                                                   : int'($urandom_range(0, 999)));
      m_car = 0; s_car = 0; m_inv = 0;
      if (r_clr) begin
        m_cnt = '0; s_cnt = '0; m_ovf = 0; s_ovf = 0;
      end else if (r_ld) begin
        if (CHECKED && !all_bcd(rv)) m_inv = 1;
        else begin m_cnt = rv; s_cnt = rv; end
      end else if (r_en) begin
        model_step(m_cnt, r_dn, nxt, wr);
        m_cnt = nxt;
        if (wr) begin m_car = 1; m_ovf = 1; end
        model_step(s_cnt, r_dn, nxt, wr);
        if (wr) begin s_car = 1; s_ovf = 1; end
        else s_cnt = nxt;
      end
      cyc(r_clr, r_ld, rv, r_en, r_dn);
      check("rnd_count", 32'(Count),     32'(m_cnt));
      check("rnd_carry", 32'(Carry),     32'(m_car));
      check("rnd_ovf",   32'(Overflow),  32'(m_ovf));
      check("rnd_inv",   32'(Invalid),   32'(m_inv));
      check("rnd_term",  32'(Terminal),  32'(term_of(m_cnt, r_dn)));
      check("rnd_s_count", 32'(s_count), 32'(s_cnt));
      check("rnd_s_carry", 32'(s_carry), 32'(s_car));
      check("rnd_s_ovf",   32'(s_overflow), 32'(s_ovf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
